// File: rtl/alu_exec_pkg.sv
// pkg_reg / pkg_alu: register-file geometry and ALU encodings shared by the execute stage.
// Rev 1.0
`default_nettype none

package pkg_reg;
  localparam int REG_WIDTH = 64;
  localparam int REG_ADDRW = 8;
endpackage

package pkg_alu;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_MUL = 3'd7
  } op_t;

  typedef enum logic [0:0] {
    ALU_REG = 1'b0,
    ALU_IMM = 1'b1
  } sel_t;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_O    = 2;
  localparam int FLAG_S    = 3;
  localparam int NUM_FLAGS = 4;
endpackage

`default_nettype wire

// File: rtl/if_instr_alu.sv
// if_instr_alu: decoded ALU instruction handed from the decoder (client) to the execute stage (server).
// Rev 1.0
`default_nettype none

interface if_instr_alu;
  pkg_alu::op_t                     op;
  pkg_alu::sel_t                    a_sel;
  logic [pkg_reg::REG_ADDRW-1:0]    s_reg;
  logic [pkg_reg::REG_ADDRW-1:0]    b_reg;
  logic [pkg_reg::REG_ADDRW-1:0]    a_reg;
  logic [pkg_reg::REG_WIDTH-1:0]    a_imm;

  modport server (input op, a_sel, s_reg, b_reg, a_reg, a_imm);
  modport client (output op, a_sel, s_reg, b_reg, a_reg, a_imm);
endinterface

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, MUL_STEP multiplier bits per cycle, low half of product.
// Rev 1.0
`default_nettype none

module alu_mul_iter #(
  parameter int REG_WIDTH = 64,
  parameter int MUL_STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic                 last,
  output logic [REG_WIDTH-1:0] product
);
  localparam int STEPS = REG_WIDTH / MUL_STEP;
  localparam int CNTW  = $clog2(STEPS + 1);

  logic [REG_WIDTH-1:0] acc;
  logic [REG_WIDTH-1:0] mcand;
  logic [REG_WIDTH-1:0] mplier;
  logic [REG_WIDTH-1:0] pp;
  logic [REG_WIDTH-1:0] mc_in;
  logic [MUL_STEP-1:0]  bits_in;
  logic [CNTW-1:0]      cnt;
  logic                 run;

  // The start cycle already retires the first slice straight from the operand inputs.
  always_comb begin
    mc_in   = start ? b : mcand;
    bits_in = start ? a[MUL_STEP-1:0] : mplier[MUL_STEP-1:0];
    pp      = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (bits_in[j]) pp = pp + (mc_in << j);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= pp;
      mcand  <= b << MUL_STEP;
      mplier <= a >> MUL_STEP;
      cnt    <= CNTW'(STEPS - 1);
      run    <= (STEPS > 1);
    end else if (run) begin
      acc    <= acc + pp;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      cnt    <= cnt - 1'b1;
      if (cnt == CNTW'(1)) run <= 1'b0;
    end
  end

  assign last    = start ? (STEPS == 1) : (run && (cnt == CNTW'(1)));
  assign product = acc;
endmodule

`default_nettype wire

// File: rtl/alu_exec.sv
// alu_exec: execute stage, s <- b op a with register-file read, iterative MUL, write-back and flags.
// Rev 1.0
`default_nettype none

module alu_exec
  import pkg_alu::*;
#(
  parameter int REG_WIDTH = pkg_reg::REG_WIDTH,
  parameter int REG_ADDRW = pkg_reg::REG_ADDRW,
  parameter int MUL_STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  if_instr_alu.server          instr,
  output logic                 busy,
  output logic                 done,
  output logic [REG_ADDRW-1:0] rd_a_addr,
  output logic [REG_ADDRW-1:0] rd_b_addr,
  input  logic [REG_WIDTH-1:0] rd_a_data,
  input  logic [REG_WIDTH-1:0] rd_b_data,
  output logic                 wr_en,
  output logic [REG_ADDRW-1:0] wr_addr,
  output logic [REG_WIDTH-1:0] wr_data,
  output logic                 zf,
  output logic                 cf,
  output logic                 of,
  output logic                 sf
);
  localparam int SHW = $clog2(REG_WIDTH);
  localparam int MSB = REG_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    MUL  = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t               state, state_nx;
  op_t                  op_q;
  sel_t                 a_sel_q;
  logic [REG_ADDRW-1:0] s_reg_q, b_reg_q, a_reg_q;
  logic [REG_WIDTH-1:0] a_imm_q;
  logic [REG_WIDTH-1:0] res;
  logic                 cf_pend, of_pend;
  logic [NUM_FLAGS-1:0] flags;
  logic                 mul_first, mul_start, mul_last;
  logic [REG_WIDTH-1:0] mul_product;

  logic [REG_WIDTH-1:0] opa;
  logic [REG_WIDTH:0]   sum, diff;
  logic [REG_WIDTH-1:0] alu_res;
  logic                 alu_cf, alu_of, op_ok;

  assign opa  = (a_sel_q == ALU_IMM) ? a_imm_q : rd_a_data;
  assign sum  = {1'b0, rd_b_data} + {1'b0, opa};
  assign diff = {1'b0, rd_b_data} - {1'b0, opa};

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    op_ok   = 1'b1;
    case (op_q)
      ALU_ADD: begin
        alu_res = sum[MSB:0];
        alu_cf  = sum[REG_WIDTH];
        alu_of  = (rd_b_data[MSB] == opa[MSB]) && (alu_res[MSB] != rd_b_data[MSB]);
      end
      ALU_SUB: begin
        alu_res = diff[MSB:0];
        alu_cf  = diff[REG_WIDTH];
        alu_of  = (rd_b_data[MSB] != opa[MSB]) && (alu_res[MSB] != rd_b_data[MSB]);
      end
      ALU_AND: alu_res = rd_b_data & opa;
      ALU_OR:  alu_res = rd_b_data | opa;
      ALU_XOR: alu_res = rd_b_data ^ opa;
      ALU_SHL: alu_res = rd_b_data << opa[SHW-1:0];
      ALU_SHR: alu_res = rd_b_data >> opa[SHW-1:0];
      ALU_MUL: alu_res = '0;
      default: op_ok = 1'b0;
    endcase
  end

  alu_mul_iter #(
    .REG_WIDTH (REG_WIDTH),
    .MUL_STEP  (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (opa),
    .b       (rd_b_data),
    .last    (mul_last),
    .product (mul_product)
  );

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: if (start) state_nx = READ;
      READ: begin
        busy     = 1'b1;
        state_nx = (op_q == ALU_MUL) ? MUL : EXEC;
      end
      EXEC: begin
        busy     = 1'b1;
        state_nx = WB;
      end
      MUL: begin
        busy      = 1'b1;
        mul_start = mul_first;
        if (mul_last) state_nx = WB;
      end
      WB: begin
        busy     = 1'b1;
        done     = 1'b1;
        wr_en    = op_ok && (s_reg_q != '0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= ALU_ADD;
      a_sel_q   <= ALU_REG;
      s_reg_q   <= '0;
      b_reg_q   <= '0;
      a_reg_q   <= '0;
      a_imm_q   <= '0;
      res       <= '0;
      cf_pend   <= 1'b0;
      of_pend   <= 1'b0;
      flags     <= '0;
      mul_first <= 1'b0;
    end else begin
      state     <= state_nx;
      mul_first <= (state == READ);
      if (state == IDLE && start) begin
        op_q    <= instr.op;
        a_sel_q <= instr.a_sel;
        s_reg_q <= instr.s_reg;
        b_reg_q <= instr.b_reg;
        a_reg_q <= instr.a_reg;
        a_imm_q <= instr.a_imm;
      end
      if (state == EXEC) begin
        res     <= alu_res;
        cf_pend <= alu_cf;
        of_pend <= alu_of;
      end
      // Flags commit with the write-back; only ADD/SUB own carry and overflow.
      if (state == WB && op_ok) begin
        flags[FLAG_Z] <= (wr_data == '0);
        flags[FLAG_S] <= wr_data[MSB];
        if (op_q == ALU_ADD || op_q == ALU_SUB) begin
          flags[FLAG_C] <= cf_pend;
          flags[FLAG_O] <= of_pend;
        end
      end
    end
  end

  assign rd_a_addr = a_reg_q;
  assign rd_b_addr = b_reg_q;
  assign wr_addr   = s_reg_q;
  assign wr_data   = (op_q == ALU_MUL) ? mul_product : res;
  assign zf        = flags[FLAG_Z];
  assign cf        = flags[FLAG_C];
  assign of        = flags[FLAG_O];
  assign sf        = flags[FLAG_S];
endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// tb_alu_exec: table-driven check of alu_exec against hand-computed results, plus abort and busy-start sequences.
// Rev 1.0
`default_nettype none

module tb_alu_exec;
  import pkg_alu::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, wr_en, zf, cf, of, sf;
  logic [7:0]  rd_a_addr, rd_b_addr, wr_addr;
  logic [63:0] rd_a_data, rd_b_data, wr_data;
  logic [63:0] regs [256];

  int total = 0;
  int bad   = 0;

  if_instr_alu ifc ();

  alu_exec #(.MUL_STEP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (ifc),
    .busy      (busy),
    .done      (done),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .zf        (zf),
    .cf        (cf),
    .of        (of),
    .sf        (sf)
  );

  always #5 clk = ~clk;

  // Register-file model: synchronous read, register 0 reads as zero.
  always @(posedge clk) begin
    rd_a_data <= (rd_a_addr == 8'd0) ? 64'd0 : regs[rd_a_addr];
    rd_b_data <= (rd_b_addr == 8'd0) ? 64'd0 : regs[rd_b_addr];
  end

  typedef struct {
    op_t         op;
    sel_t        sel;
    logic [7:0]  s;
    logic [63:0] bv;
    logic [63:0] av;
    logic [63:0] imm;
    logic [63:0] exp_data;
    logic        exp_we;
    logic [3:0]  exp_fl;   // {zf, cf, of, sf}
    int          lat;
    int          start2;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(op_t op, sel_t sel, logic [7:0] s, logic [63:0] bv, logic [63:0] av,
                              logic [63:0] imm, logic [63:0] ed, logic we, logic [3:0] fl, int lat, int s2);
    vec_t v;
    v.op = op; v.sel = sel; v.s = s; v.bv = bv; v.av = av; v.imm = imm;
    v.exp_data = ed; v.exp_we = we; v.exp_fl = fl; v.lat = lat; v.start2 = s2;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(int idx, vec_t v);
    int          done_cyc = -1;
    int          wr_cnt   = 0;
    int          busy_err = 0;
    logic [7:0]  got_addr = '0;
    logic [63:0] got_data = '0;
    regs[2] = v.bv;
    regs[1] = v.av;
    @(negedge clk);
    ifc.op = v.op; ifc.a_sel = v.sel; ifc.s_reg = v.s;
    ifc.b_reg = 8'd2; ifc.a_reg = 8'd1; ifc.a_imm = v.imm;
    start = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        ifc.op = ALU_XOR; ifc.a_sel = (v.sel == ALU_REG) ? ALU_IMM : ALU_REG;
        ifc.s_reg = 8'hC8; ifc.b_reg = 8'd1; ifc.a_reg = 8'd2; ifc.a_imm = 64'h1234_5678_9ABC_DEF0;
      end
      if (k == v.start2)     start = 1'b1;
      if (k == v.start2 + 1) start = 1'b0;
      if (wr_en) begin
        wr_cnt++;
        got_addr = wr_addr;
        got_data = wr_data;
      end
      if (done_cyc < 0 && done) done_cyc = k;
      if ((done_cyc < 0 || k <= done_cyc) && !busy) busy_err++;
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        check($sformatf("v%0d flags", idx), {60'd0, zf, cf, of, sf}, {60'd0, v.exp_fl});
        check($sformatf("v%0d busy_after", idx), {63'd0, busy}, 64'd0);
      end
      if (done_cyc >= 0 && k >= done_cyc + 4) break;
    end
    check($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(v.lat));
    check($sformatf("v%0d busy_window", idx), 64'(busy_err), 64'd0);
    check($sformatf("v%0d write_count", idx), 64'(wr_cnt), {63'd0, v.exp_we});
    if (v.exp_we) begin
      check($sformatf("v%0d wr_addr", idx), {56'd0, got_addr}, {56'd0, v.s});
      check($sformatf("v%0d wr_data", idx), got_data, v.exp_data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cnt;
    for (int i = 0; i < 256; i++) regs[i] = 64'd0;
    rst_n = 1'b0; start = 1'b0;
    ifc.op = ALU_ADD; ifc.a_sel = ALU_REG; ifc.s_reg = '0; ifc.b_reg = '0; ifc.a_reg = '0; ifc.a_imm = '0;

    vecs[0]  = mk(ALU_ADD, ALU_REG, 8'd3,  64'd7, 64'd5, 64'd0, 64'd12, 1'b1, 4'b0000, 3, -1);
    vecs[1]  = mk(ALU_SUB, ALU_IMM, 8'd4,  64'd3, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'b0101, 3, -1);
    vecs[2]  = mk(ALU_ADD, ALU_IMM, 8'd5,  64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 4'b0011, 3, -1);
    vecs[3]  = mk(ALU_AND, ALU_IMM, 8'd6,  64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, 1'b1, 4'b1010, 3, -1);
    vecs[4]  = mk(ALU_OR,  ALU_REG, 8'd7,  64'hF0, 64'h0F, 64'd0, 64'hFF, 1'b1, 4'b0010, 3, -1);
    vecs[5]  = mk(ALU_XOR, ALU_IMM, 8'd8,  64'hFF, 64'd0, 64'h0F, 64'hF0, 1'b1, 4'b0010, 3, -1);
    vecs[6]  = mk(ALU_SHL, ALU_IMM, 8'd9,  64'd1, 64'd0, 64'd127, 64'h8000_0000_0000_0000, 1'b1, 4'b0011, 3, -1);
    vecs[7]  = mk(ALU_SHR, ALU_IMM, 8'd10, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 64'h0800_0000_0000_0000, 1'b1, 4'b0010, 3, -1);
    vecs[8]  = mk(ALU_SUB, ALU_REG, 8'd11, 64'd5, 64'd5, 64'd0, 64'd0, 1'b1, 4'b1000, 3, -1);
    vecs[9]  = mk(ALU_ADD, ALU_IMM, 8'd0,  64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 4'b1100, 3, -1);
    vecs[10] = mk(ALU_SUB, ALU_IMM, 8'd12, 64'h8000_0000_0000_0000, 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'b0010, 3, -1);
    vecs[11] = mk(ALU_MUL, ALU_REG, 8'd13, 64'h1_0000_0001, 64'h1_0000_0003, 64'd0, 64'h4_0000_0003, 1'b1, 4'b0010, 66, 10);
    vecs[12] = mk(ALU_MUL, ALU_IMM, 8'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'b0011, 66, -1);
    vecs[13] = mk(ALU_ADD, ALU_REG, 8'd16, 64'd2, 64'd3, 64'd0, 64'd5, 1'b1, 4'b0000, 3, -1);

    repeat (3) @(negedge clk);
    check("reset busy",  {63'd0, busy},  64'd0);
    check("reset done",  {63'd0, done},  64'd0);
    check("reset wr_en", {63'd0, wr_en}, 64'd0);
    check("reset flags", {60'd0, zf, cf, of, sf}, 64'd0);
    check("reset wr_data", wr_data, 64'd0);
    check("reset addrs", {40'd0, rd_a_addr, rd_b_addr, wr_addr}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Abort a MUL with reset in its cycle 20.
    regs[2] = 64'd3; regs[1] = 64'd4;
    @(negedge clk);
    ifc.op = ALU_MUL; ifc.a_sel = ALU_REG; ifc.s_reg = 8'd15; ifc.b_reg = 8'd2; ifc.a_reg = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy",  {63'd0, busy},  64'd0);
    check("abort wr_en", {63'd0, wr_en}, 64'd0);
    check("abort flags", {60'd0, zf, cf, of, sf}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (wr_en || done || busy) wr_cnt++;
    end
    check("abort no_write", 64'(wr_cnt), 64'd0);

    run_vec(13, vecs[13]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
